// File: rtl/nx_stream_collector.sv
// nx_stream_collector: mesh-edge sink for one nx_node outbound stream.
// It advertises presence to the node, accepts messages under valid/ready
// into a small first-word-fall-through FIFO, counts accepted messages and
// misrouted ones (header row/col != own address), and presents the head
// message to the host through a second valid/ready interface.
//
// Ports:
//   clk_i, rst_i (async active-low), flush_i (sync FIFO clear)
//   coll_row_i / coll_col_i   : this collector's mesh address
//   ib_data_i / ib_valid_i / ib_ready_o / ib_present_o : node side
//   out_data_o / out_command_o / out_valid_o / out_ready_i : host side
//   rx_count_o / misroute_count_o : wrapping message counters
//   idle_o                    : FIFO empty and no inbound valid
module nx_stream_collector #(
  parameter int unsigned STREAM_WIDTH   = 32,
  parameter int unsigned ADDR_ROW_WIDTH = 4,
  parameter int unsigned ADDR_COL_WIDTH = 4,
  parameter int unsigned COMMAND_WIDTH  = 2,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned COUNT_WIDTH    = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic [ADDR_ROW_WIDTH-1:0] coll_row_i,
  input  logic [ADDR_COL_WIDTH-1:0] coll_col_i,
  input  logic [STREAM_WIDTH-1:0]   ib_data_i,
  input  logic                      ib_valid_i,
  output logic                      ib_ready_o,
  output logic                      ib_present_o,
  output logic [STREAM_WIDTH-1:0]   out_data_o,
  output logic [COMMAND_WIDTH-1:0]  out_command_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [COUNT_WIDTH-1:0]    rx_count_o,
  output logic [COUNT_WIDTH-1:0]    misroute_count_o,
  output logic                      idle_o
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned PW      = AW + 1;
  localparam int unsigned ROW_LSB = STREAM_WIDTH - ADDR_ROW_WIDTH;
  localparam int unsigned COL_LSB = ROW_LSB - ADDR_COL_WIDTH;
  localparam int unsigned CMD_LSB = COL_LSB - COMMAND_WIDTH;

  logic [STREAM_WIDTH-1:0]   r_mem [DEPTH];
  logic [PW-1:0]             r_wr_ptr;
  logic [PW-1:0]             r_rd_ptr;
  logic                      r_present;
  logic [COUNT_WIDTH-1:0]    r_rx_count;
  logic [COUNT_WIDTH-1:0]    r_mis_count;

  logic                      w_full;
  logic                      w_empty;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_misroute;
  logic [AW-1:0]             w_wr_addr;
  logic [AW-1:0]             w_rd_addr;
  logic [ADDR_ROW_WIDTH-1:0] w_in_row;
  logic [ADDR_COL_WIDTH-1:0] w_in_col;

  // Pointer status: extra MSB is the wrap bit distinguishing full from empty.
  assign w_wr_addr = r_wr_ptr[AW-1:0];
  assign w_rd_addr = r_rd_ptr[AW-1:0];
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (w_wr_addr == w_rd_addr) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // Full is sampled before any same-cycle pop, so a full FIFO refuses input
  // even while it drains; flush also blocks the inbound handshake.
  assign ib_ready_o   = r_present & ~w_full & ~flush_i;
  assign ib_present_o = r_present;
  assign w_push       = ib_valid_i & ib_ready_o;
  assign w_pop        = ~w_empty & out_ready_i & ~flush_i;

  // Header decode of the inbound message for misroute detection.
  assign w_in_row   = ib_data_i[ROW_LSB +: ADDR_ROW_WIDTH];
  assign w_in_col   = ib_data_i[COL_LSB +: ADDR_COL_WIDTH];
  assign w_misroute = (w_in_row != coll_row_i) || (w_in_col != coll_col_i);

  // Head presentation; gated to zero while empty so stale entries never show.
  assign out_valid_o   = ~w_empty;
  assign out_data_o    = w_empty ? '0 : r_mem[w_rd_addr];
  assign out_command_o = out_data_o[CMD_LSB +: COMMAND_WIDTH];

  assign rx_count_o       = r_rx_count;
  assign misroute_count_o = r_mis_count;
  assign idle_o           = w_empty & ~ib_valid_i;

  // Presence: rises on the first edge after reset release and stays high.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_present <= 1'b0;
    end else begin
      r_present <= 1'b1;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[w_wr_addr] <= ib_data_i;
    end
  end

  // Read/write pointers; flush overrides push and pop.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  // Message counters; not affected by flush, wrap naturally.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rx_count  <= '0;
      r_mis_count <= '0;
    end else if (w_push) begin
      r_rx_count <= r_rx_count + COUNT_WIDTH'(1);
      if (w_misroute) begin
        r_mis_count <= r_mis_count + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_nx_stream_collector.sv
// Self-checking bench for nx_stream_collector: directed scenarios plus a
// randomized phase, all compared against a queue-based reference model.
module tb_nx_stream_collector;

  localparam int unsigned SW    = 32;
  localparam int unsigned RW    = 4;
  localparam int unsigned CW    = 4;
  localparam int unsigned CMW   = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNTW  = 16;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            flush_i;
  logic [RW-1:0]   coll_row_i;
  logic [CW-1:0]   coll_col_i;
  logic [SW-1:0]   ib_data_i;
  logic            ib_valid_i;
  logic            ib_ready_o;
  logic            ib_present_o;
  logic [SW-1:0]   out_data_o;
  logic [CMW-1:0]  out_command_o;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [CNTW-1:0] rx_count_o;
  logic [CNTW-1:0] misroute_count_o;
  logic            idle_o;

  nx_stream_collector #(
    .STREAM_WIDTH(SW), .ADDR_ROW_WIDTH(RW), .ADDR_COL_WIDTH(CW),
    .COMMAND_WIDTH(CMW), .DEPTH(DEPTH), .COUNT_WIDTH(CNTW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .coll_row_i(coll_row_i), .coll_col_i(coll_col_i),
    .ib_data_i(ib_data_i), .ib_valid_i(ib_valid_i), .ib_ready_o(ib_ready_o),
    .ib_present_o(ib_present_o), .out_data_o(out_data_o),
    .out_command_o(out_command_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .rx_count_o(rx_count_o),
    .misroute_count_o(misroute_count_o), .idle_o(idle_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model state.
  logic [SW-1:0]   q[$];
  logic [SW-1:0]   dut_popped[$];
  bit              m_present;
  logic [CNTW-1:0] m_rx;
  logic [CNTW-1:0] m_mis;
  bit              dut_acc;
  int              checks = 0;
  int              errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_misroute(input logic [SW-1:0] d);
    int unsigned row, col;
    row = (d >> (SW - RW)) % (1 << RW);
    col = (d >> (SW - RW - CW)) % (1 << CW);
    return (row != int'(coll_row_i)) || (col != int'(coll_col_i));
  endfunction

  task automatic check_outputs();
    logic [SW-1:0] head;
    int unsigned   cmd;
    head = (q.size() > 0) ? q[0] : '0;
    cmd  = (head >> (SW - RW - CW - CMW)) % (1 << CMW);
    chk("present",   64'(ib_present_o), 64'(m_present));
    chk("ib_ready",  64'(ib_ready_o),
        64'(m_present && (q.size() < DEPTH) && !flush_i));
    chk("out_valid", 64'(out_valid_o), 64'(q.size() > 0));
    chk("out_data",  64'(out_data_o), 64'(head));
    chk("out_cmd",   64'(out_command_o), 64'(cmd));
    chk("rx_count",  64'(rx_count_o), 64'(m_rx));
    chk("mis_count", 64'(misroute_count_o), 64'(m_mis));
    chk("idle",      64'(idle_o), 64'((q.size() == 0) && !ib_valid_i));
  endtask

  // One clock cycle: check at negedge, advance the model at posedge.
  task automatic step();
    bit do_push, do_pop;
    @(negedge clk_i);
    check_outputs();
    dut_acc = ib_valid_i && ib_ready_o;
    if (out_valid_o && out_ready_i && !flush_i) dut_popped.push_back(out_data_o);
    do_push = ib_valid_i && m_present && (q.size() < DEPTH) && !flush_i;
    do_pop  = (q.size() > 0) && out_ready_i && !flush_i;
    @(posedge clk_i);
    if (!rst_i) begin
      q.delete(); m_present = 0; m_rx = '0; m_mis = '0;
    end else begin
      if (flush_i) begin
        q.delete();
      end else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(ib_data_i);
      end
      if (do_push) begin
        m_rx++;
        if (is_misroute(ib_data_i)) m_mis++;
      end
      m_present = 1;
    end
    #1;
  endtask

  initial begin
    int n;
    int cyc;
    logic [CNTW-1:0] saved_rx;
    logic [SW-1:0] exp_seq[$];
    rst_i = 0; flush_i = 0; coll_row_i = 4'd2; coll_col_i = 4'd3;
    ib_data_i = '0; ib_valid_i = 0; out_ready_i = 0;
    q.delete(); m_present = 0; m_rx = '0; m_mis = '0;

    // Reset release.
    repeat (5) step();
    chk("rst_present", 64'(ib_present_o), 64'(0));
    rst_i = 1;
    step();
    chk("rel_present", 64'(ib_present_o), 64'(1));
    chk("rel_ready",   64'(ib_ready_o), 64'(1));
    chk("rel_idle",    64'(idle_o), 64'(1));

    // Single message with matching address.
    out_ready_i = 1; ib_valid_i = 1; ib_data_i = 32'h23C0_1234;
    step();
    ib_valid_i = 0;
    chk("single_acc",   64'(dut_acc), 64'(1));
    chk("single_valid", 64'(out_valid_o), 64'(1));
    chk("single_data",  64'(out_data_o), 64'h23C0_1234);
    chk("single_cmd",   64'(out_command_o), 64'(3));
    step();
    chk("single_rx",  64'(rx_count_o), 64'(1));
    chk("single_mis", 64'(misroute_count_o), 64'(0));

    // Misroute: stored and delivered, counted.
    ib_valid_i = 1; ib_data_i = 32'h5400_0001;
    step();
    ib_valid_i = 0;
    chk("mis_data", 64'(out_data_o), 64'h5400_0001);
    step();
    chk("mis_count2", 64'(misroute_count_o), 64'(1));
    chk("mis_rx2",    64'(rx_count_o), 64'(2));

    // Backpressure: 4 of 6 accepted while host stalls, then drain in order.
    dut_popped.delete();
    out_ready_i = 0; n = 0;
    for (int c = 0; c < 10; c++) begin
      ib_valid_i = (n < 6); ib_data_i = 32'h2300_0000 + 32'(n);
      step();
      if (dut_acc) n++;
    end
    chk("bp_accepted", 64'(n), 64'(4));
    chk("bp_ready_full", 64'(ib_ready_o), 64'(0));
    out_ready_i = 1; cyc = 0;
    while (n < 6 && cyc < 20) begin
      ib_valid_i = 1; ib_data_i = 32'h2300_0000 + 32'(n);
      step();
      if (dut_acc) n++;
      cyc++;
    end
    chk("bp_timeout", 64'(n), 64'(6));
    ib_valid_i = 0;
    repeat (8) step();
    chk("bp_count", 64'(dut_popped.size()), 64'(6));
    for (int i = 0; i < 6; i++)
      chk("bp_order", 64'((i < dut_popped.size()) ? dut_popped[i] : '0),
          64'(32'h2300_0000 + 32'(i)));

    // Throughput and pointer wrap: 100 back-to-back messages.
    dut_popped.delete(); exp_seq.delete();
    saved_rx = rx_count_o;
    out_ready_i = 1;
    for (int i = 0; i < 100; i++) begin
      ib_valid_i = 1; ib_data_i = {4'd2, 4'd3, 24'(i * 7 + 1)};
      exp_seq.push_back(ib_data_i);
      step();
      if (i == 0 || i == 50 || i == 99) chk("tput_acc", 64'(dut_acc), 64'(1));
    end
    ib_valid_i = 0;
    repeat (3) step();
    chk("tput_rx", 64'(rx_count_o - saved_rx), 64'(100));
    chk("tput_count", 64'(dut_popped.size()), 64'(100));
    n = 0;
    for (int i = 0; i < 100 && i < dut_popped.size(); i++)
      if (dut_popped[i] !== exp_seq[i]) n++;
    chk("tput_order", 64'(n), 64'(0));

    // Flush with 3 buffered.
    out_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      ib_valid_i = 1; ib_data_i = 32'h2380_0010 + 32'(i);
      step();
    end
    ib_valid_i = 0;
    step();
    saved_rx = m_rx;
    chk("fl_pre_valid", 64'(out_valid_o), 64'(1));
    flush_i = 1; ib_valid_i = 1; ib_data_i = 32'h2300_00AA;
    step();
    flush_i = 0; ib_valid_i = 0;
    chk("fl_valid", 64'(out_valid_o), 64'(0));
    chk("fl_rx",    64'(rx_count_o), 64'(saved_rx));
    step();

    // Randomized traffic.
    ib_valid_i = 0;
    for (int c = 0; c < 400; c++) begin
      if (!(ib_valid_i && !dut_acc)) begin
        ib_valid_i = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) == 0) ib_data_i = $urandom();
        else ib_data_i = {4'd2, 4'd3, 24'($urandom())};
      end
      out_ready_i = ($urandom_range(0, 2) != 0);
      flush_i     = ($urandom_range(0, 31) == 0);
      step();
    end
    flush_i = 0;

    // Reset mid-operation with 2 buffered.
    out_ready_i = 0; ib_valid_i = 1;
    ib_data_i = 32'h2340_0001; step();
    ib_data_i = 32'h2340_0002; step();
    ib_valid_i = 0;
    step();
    #2 rst_i = 0;
    #1;
    q.delete(); m_present = 0; m_rx = '0; m_mis = '0;
    check_outputs();
    chk("rst_valid", 64'(out_valid_o), 64'(0));
    step();
    rst_i = 1;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
